// File: rtl/mem_port_arbiter.sv
// Shares the single burst memory port between the write-back buffer (LW), the D-cache
// line fill (DL) and the I-cache refill (IL), one whole cache line per transaction.

module mem_port_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int CNT_W      = 3,
    parameter int STARVE_MAX = 3
) (
    input  logic             Clk,
    input  logic             Rst,

    input  logic             LW_Req_i,
    input  logic             DL_Req_i,
    input  logic             IL_Req_i,
    input  logic [31:0]      LW_Addr_i,
    input  logic [31:0]      DL_Addr_i,
    input  logic [31:0]      IL_Addr_i,
    input  logic [31:0]      LW_WData_i,

    output logic             LW_WReady_o,
    output logic             DL_RValid_o,
    output logic             IL_RValid_o,
    output logic             DL_FirstWord_o,
    output logic             IL_FirstWord_o,
    output logic             LW_Done_o,
    output logic             DL_Done_o,
    output logic             IL_Done_o,
    output logic [31:0]      RData_o,
    output logic [CNT_W-1:0] BeatIdx_o,
    output logic             Busy_o,

    output logic             M_Req_o,
    output logic             M_Write_o,
    output logic [31:0]      M_Addr_o,
    input  logic             M_Ack_i,
    input  logic             M_RValid_i,
    input  logic [31:0]      M_RData_i,
    output logic             M_WValid_o,
    output logic [31:0]      M_WData_o,
    input  logic             M_WReady_i
);

    localparam int               TAG_LSB    = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(LINE_WORDS - 1);
    localparam logic [1:0]       STARVE_LIM = 2'(STARVE_MAX);
    localparam int               OWN_LW     = 0;
    localparam int               OWN_DL     = 1;
    localparam int               OWN_IL     = 2;

    typedef enum logic [2:0] {IDLE, CMD, RDATA, WDATA, DONE} state_t;

    state_t           state_q;
    logic [2:0]       owner_q;
    logic [2:0]       doneMask_q;
    logic [2:0]       done_q;
    logic [31:0]      mAddr_q;
    logic [CNT_W-1:0] startWord_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       starveCnt_q;
    logic [1:0]       starveCnt_d;
    logic             lastWasDl_q;
    logic             mReq_q;
    logic             mWrite_q;
    logic             mWValid_q;
    logic             busy_q;

    logic             lwEff;
    logic             dlEff;
    logic             ilEff;
    logic             hazard;
    logic             starved;
    logic [2:0]       grant;
    logic             readGrant;
    logic             inRead;
    logic             inWrite;
    logic             beat;
    logic             lastBeat;
    logic             unusedAddrBits;

    // A requester that just finished is ignored for the single IDLE cycle after its Done.
    assign lwEff = LW_Req_i & ~doneMask_q[OWN_LW];
    assign dlEff = DL_Req_i & ~doneMask_q[OWN_DL];
    assign ilEff = IL_Req_i & ~doneMask_q[OWN_IL];

    assign hazard = lwEff &
                    ((dlEff & (DL_Addr_i[31:TAG_LSB] == LW_Addr_i[31:TAG_LSB])) |
                     (ilEff & (IL_Addr_i[31:TAG_LSB] == LW_Addr_i[31:TAG_LSB])));
    assign starved = lwEff & (starveCnt_q == STARVE_LIM);

    always_comb begin
        grant = '0;
        if (hazard || starved) begin
            grant[OWN_LW] = 1'b1;
        end else if (dlEff && ilEff) begin
            if (lastWasDl_q) grant[OWN_IL] = 1'b1;
            else             grant[OWN_DL] = 1'b1;
        end else if (dlEff) begin
            grant[OWN_DL] = 1'b1;
        end else if (ilEff) begin
            grant[OWN_IL] = 1'b1;
        end else if (lwEff) begin
            grant[OWN_LW] = 1'b1;
        end
    end

    assign readGrant = grant[OWN_DL] | grant[OWN_IL];

    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!LW_Req_i) begin
            starveCnt_d = '0;
        end else if (state_q == IDLE && grant[OWN_LW]) begin
            starveCnt_d = '0;
        end else if (state_q == IDLE && readGrant && starveCnt_q != STARVE_LIM) begin
            starveCnt_d = starveCnt_q + 2'd1;
        end
    end

    assign inRead   = (state_q == RDATA);
    assign inWrite  = (state_q == WDATA);
    assign beat     = (inRead & M_RValid_i) | (inWrite & M_WReady_i);
    assign lastBeat = beat & (cnt_q == LAST_BEAT);

    // Reads go critical-word-first from the requested word; write-backs always start at word 0.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            doneMask_q  <= '0;
            done_q      <= '0;
            mAddr_q     <= '0;
            startWord_q <= '0;
            cnt_q       <= '0;
            starveCnt_q <= '0;
            lastWasDl_q <= 1'b0;
            mReq_q      <= 1'b0;
            mWrite_q    <= 1'b0;
            mWValid_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            starveCnt_q <= starveCnt_d;
            doneMask_q  <= (state_q == DONE) ? owner_q : 3'b000;
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        owner_q  <= grant;
                        mReq_q   <= 1'b1;
                        mWrite_q <= grant[OWN_LW];
                        busy_q   <= 1'b1;
                        state_q  <= CMD;
                        if (grant[OWN_LW]) begin
                            mAddr_q     <= {LW_Addr_i[31:TAG_LSB], {TAG_LSB{1'b0}}};
                            startWord_q <= '0;
                        end else if (grant[OWN_DL]) begin
                            mAddr_q     <= {DL_Addr_i[31:2], 2'b00};
                            startWord_q <= DL_Addr_i[TAG_LSB-1:2];
                            lastWasDl_q <= 1'b1;
                        end else begin
                            mAddr_q     <= {IL_Addr_i[31:2], 2'b00};
                            startWord_q <= IL_Addr_i[TAG_LSB-1:2];
                            lastWasDl_q <= 1'b0;
                        end
                    end
                end
                CMD: begin
                    cnt_q <= '0;
                    if (M_Ack_i) begin
                        mReq_q <= 1'b0;
                        if (mWrite_q) begin
                            mWValid_q <= 1'b1;
                            state_q   <= WDATA;
                        end else begin
                            state_q   <= RDATA;
                        end
                    end
                end
                RDATA, WDATA: begin
                    if (lastBeat) begin
                        mWValid_q <= 1'b0;
                        done_q    <= owner_q;
                        state_q   <= DONE;
                    end else if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign M_Req_o        = mReq_q;
    assign M_Write_o      = mWrite_q;
    assign M_Addr_o       = mAddr_q;
    assign M_WValid_o     = mWValid_q;
    assign M_WData_o      = mWValid_q ? LW_WData_i : 32'd0;
    assign Busy_o         = busy_q;

    assign LW_Done_o      = done_q[OWN_LW];
    assign DL_Done_o      = done_q[OWN_DL];
    assign IL_Done_o      = done_q[OWN_IL];

    assign RData_o        = inRead ? M_RData_i : 32'd0;
    assign DL_RValid_o    = inRead & owner_q[OWN_DL] & M_RValid_i;
    assign IL_RValid_o    = inRead & owner_q[OWN_IL] & M_RValid_i;
    assign DL_FirstWord_o = DL_RValid_o & (cnt_q == '0);
    assign IL_FirstWord_o = IL_RValid_o & (cnt_q == '0);
    assign LW_WReady_o    = inWrite & M_WReady_i;
    assign BeatIdx_o      = (inRead || inWrite) ? (startWord_q + cnt_q) : '0;

    // Byte and word offsets below line granularity do not steer anything for these inputs.
    assign unusedAddrBits = ^{LW_Addr_i[TAG_LSB-1:0], DL_Addr_i[1:0], IL_Addr_i[1:0]};

endmodule
